// File: rtl/multi_divider.sv
// Multi-channel clock-enable divider with runtime-loadable terminal values.
// Define MULTI_DIVIDER_SYNC_EN to add the SYNC phase-align input.

module multi_divider_ch #(
  parameter int          WIDTH     = 27,
  parameter int unsigned RESET_DIV = 99999999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             en,
  input  logic             sync,
  input  logic             ld_we,
  input  logic [WIDTH-1:0] ld_div,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tgl,
  output logic             pending
);

  logic [WIDTH-1:0] q_q, q_d, active_q, active_d, shadow_q, shadow_d;
  logic             tick_q, tick_d, tgl_q, tgl_d, pending_q, pending_d;

  always_comb begin
    q_d       = q_q;
    tick_d    = 1'b0;
    tgl_d     = tgl_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (sync && en) begin
      q_d   = '0;
      tgl_d = 1'b0;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (!en) begin
      q_d   = '0;
      tgl_d = 1'b0;
      // Idle channel: no wrap to wait for, so take the divisor immediately.
      if (ld_we) active_d = ld_div;
    end else if (ce) begin
      if (q_q == active_q) begin
        q_d    = '0;
        tick_d = 1'b1;
        tgl_d  = ~tgl_q;
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
    // Acceptance implies pending was clear, so a same-edge wrap never consumes this load.
    if (en && !sync && ld_we) begin
      shadow_d  = ld_div;
      pending_d = 1'b1;
    end
    if (sync && en && ld_we) begin
      shadow_d  = ld_div;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= '0;
      tick_q    <= 1'b0;
      tgl_q     <= 1'b0;
      active_q  <= WIDTH'(RESET_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      tick_q    <= tick_d;
      tgl_q     <= tgl_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign q       = q_q;
  assign tick    = tick_q;
  assign tgl     = tgl_q;
  assign pending = pending_q;

endmodule

module multi_divider #(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 27,
  parameter int unsigned RESET_DIV = 99999999,
  parameter int          CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
`ifdef MULTI_DIVIDER_SYNC_EN
  input  logic                      SYNC,
`endif
  input  logic                      CE,
  input  logic [CHANNELS-1:0]       CH_EN,
  input  logic                      LD_VALID,
  output logic                      LD_READY,
  input  logic [CH_W-1:0]           LD_CH,
  input  logic [WIDTH-1:0]          LD_DIV,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       TICK,
  output logic [CHANNELS-1:0]       TGL
);

  logic [CHANNELS-1:0][WIDTH-1:0] q_w;
  logic [CHANNELS-1:0]            pend_w, ld_we;
  logic                           sync_w;

`ifdef MULTI_DIVIDER_SYNC_EN
  assign sync_w = SYNC;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channel indices stay ready and their data falls on the floor.
  always_comb begin
    LD_READY = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (LD_CH == CH_W'(i)) LD_READY = ~pend_w[i];
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ld_we[i] = LD_VALID & LD_READY & (LD_CH == CH_W'(i));
    multi_divider_ch #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) u_ch (
      .clk    (CLK),
      .rst_n  (RST_N),
      .ce     (CE),
      .en     (CH_EN[i]),
      .sync   (sync_w),
      .ld_we  (ld_we[i]),
      .ld_div (LD_DIV),
      .q      (q_w[i]),
      .tick   (TICK[i]),
      .tgl    (TGL[i]),
      .pending(pend_w[i])
    );
  end

  assign Q = q_w;

endmodule

// File: tb/tb_multi_divider.sv
// Directed bench for multi_divider: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_multi_divider;
  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n, ce, ld_valid, ld_ready, sync;
  logic [CH-1:0] ch_en, tick, tgl;
  logic [1:0]    ld_ch;
  logic [W-1:0]  ld_div;
  logic [CH*W-1:0] q;

  multi_divider #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(4)) dut (
    .CLK(clk), .RST_N(rst_n),
`ifdef MULTI_DIVIDER_SYNC_EN
    .SYNC(sync),
`endif
    .CE(ce), .CH_EN(ch_en), .LD_VALID(ld_valid), .LD_READY(ld_ready),
    .LD_CH(ld_ch), .LD_DIV(ld_div), .Q(q), .TICK(tick), .TGL(tgl)
  );

  always #5 clk = ~clk;

  // kind: 0 Q[ch], 1 TICK[ch], 2 TGL[ch], 3 LD_READY, 4 Q bus, 5 TICK bus, 6 TGL bus
  typedef struct { int cyc; int kind; int ch; int val; } exp_t;
  exp_t sbq[$];
  int cyc = 0, pass_cnt = 0, total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(int kind, int ch);
    case (kind)
      0: return int'(q[ch*W +: W]);
      1: return int'(tick[ch]);
      2: return int'(tgl[ch]);
      3: return int'(ld_ready);
      4: return int'(q);
      5: return int'(tick);
      default: return int'(tgl);
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0: return "Q"; 1: return "TICK"; 2: return "TGL"; 3: return "LD_READY";
      4: return "Q_bus"; 5: return "TICK_bus"; default: return "TGL_bus";
    endcase
  endfunction

  exp_t em;
  int   act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      em  = sbq.pop_front();
      act = actual(em.kind, em.ch);
      total_cnt++;
      if (em.cyc != cyc)
        $display("FAIL %s ch%0d missed: due cycle %0d, now %0d", kname(em.kind), em.ch, em.cyc, cyc);
      else if (act != em.val)
        $display("FAIL %s ch%0d cycle %0d: got %0d, expected %0d", kname(em.kind), em.ch, cyc, act, em.val);
      else
        pass_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ex(int kind, int ch, int val);
    sbq.push_back('{cyc, kind, ch, val});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int q0 [10] = '{1,2,3,4,0,1,2,3,4,0};
    int t0 [10] = '{0,0,0,0,1,0,0,0,0,1};
    int g0 [10] = '{0,0,0,0,1,1,1,1,1,0};
    int q1 [7]  = '{0,1,2,0,1,2,0};
    int t1 [7]  = '{1,0,0,1,0,0,1};
    int g1 [7]  = '{1,1,1,0,0,0,1};
    int q3 [16] = '{1,1,2,2,3,3,0,0,1,1,2,2,3,3,0,0};
    int t3 [16] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0};

    rst_n = 1'b0; ce = 1'b0; ch_en = '0; ld_valid = 1'b0; ld_ch = '0; ld_div = '0; sync = 1'b0;

    // Reset state
    step(); step();
    ex(4, 0, 0); ex(5, 0, 0); ex(6, 0, 0); ex(3, 0, 1);

    // Channel 0 with RESET_DIV=4, CE stuck high
    rst_n = 1'b1; ch_en = 4'b0001; ce = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step(); ex(0, 0, q0[j]); ex(1, 0, t0[j]); ex(2, 0, g0[j]);
    end

    // Channel 1 load D=2 while counting D=4; channel 0 loads in the meantime
    ch_en = 4'b0000; step();
    ch_en = 4'b0011; step();
    ld_valid = 1'b1; ld_ch = 2'd1; ld_div = 8'd2; ex(3, 0, 1); ex(0, 1, 1);
    step(); ld_valid = 1'b0; ex(3, 0, 0); ex(0, 1, 2);
    step(); ld_valid = 1'b1; ld_ch = 2'd0; ld_div = 8'd4; ex(3, 0, 1); ex(0, 1, 3);
    step(); ld_valid = 1'b0; ld_ch = 2'd1; ex(3, 0, 0); ex(0, 1, 4); ex(1, 1, 0);
    for (int j = 0; j < 7; j++) begin
      step(); ex(0, 1, q1[j]); ex(1, 1, t1[j]); ex(2, 1, g1[j]);
      if (j == 0) ex(3, 0, 1);
    end
    ld_ch = 2'd0; ex(3, 0, 1);

    // Channel 3: D=3 loaded while disabled, CE every other cycle
    ch_en = 4'b0000; ld_valid = 1'b1; ld_ch = 2'd3; ld_div = 8'd3;
    step(); ld_valid = 1'b0; ex(3, 0, 1);
    ch_en = 4'b1000;
    for (int j = 1; j <= 16; j++) begin
      ce = (j % 2 == 1);
      step(); ex(0, 3, q3[j-1]); ex(1, 3, t3[j-1]);
    end

    // Channel 2: D=0 via direct load, then enable
    ch_en = 4'b0000; ce = 1'b1; ld_valid = 1'b1; ld_ch = 2'd2; ld_div = 8'd0;
    step(); ld_valid = 1'b0; ex(3, 0, 1); ex(2, 2, 0);
    ch_en = 4'b0100;
    for (int j = 1; j <= 4; j++) begin
      step(); ex(0, 2, 0); ex(1, 2, 1); ex(2, 2, j % 2);
    end

    // Reset mid-count with a load pending on channel 0
    ch_en = 4'b0000; step();
    ch_en = 4'b0001; step();
    ld_valid = 1'b1; ld_ch = 2'd0; ld_div = 8'd1;
    step(); ld_valid = 1'b0;
    step(); ex(3, 0, 0); ex(0, 0, 3);
    rst_n = 1'b0;
    step(); ex(4, 0, 0); ex(5, 0, 0); ex(6, 0, 0); ex(3, 0, 1);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step(); ex(0, 0, q0[j]); ex(1, 0, t0[j]);
    end

`ifdef MULTI_DIVIDER_SYNC_EN
    // Phase-align channels 0 and 1 with SYNC
    step(); step(); ex(0, 0, 2);
    ch_en = 4'b0011;
    step(); ex(0, 0, 3); ex(0, 1, 1);
    sync = 1'b1;
    step(); sync = 1'b0; ex(4, 0, 0); ex(5, 0, 0); ex(6, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      step(); ex(0, 0, j % 5); ex(0, 1, j % 5); ex(5, 0, (j == 5) ? 3 : 0);
    end
`endif

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multi_divider.md
# multi_divider

Parametrised multi-channel clock-enable divider: successor to the single fixed-modulo divider. Each channel counts global `CE` pulses up to a runtime-loadable terminal value and emits a one-cycle `TICK` plus a toggling `TGL` output at each wrap. Divisors are written through a valid/ready load port and applied glitch-free at the channel's next wrap. It sits beside the system clock and drives slow enables (display scan, debounce, 1 Hz time base) for the rest of the design.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 27: counter and divisor width in bits.
- `RESET_DIV`, 99999999: terminal value loaded into every channel at reset (1 Hz tick at 100 MHz).
- `CH_W`, derived `max(1,$clog2(CHANNELS))`: channel index width; not to be overridden.

- `CLK`  in  1  system clock, all logic on rising edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `CE`  in  1  global count enable; counters advance only in cycles with `CE`=1.
- `CH_EN`  in  CHANNELS  per-channel enable.
- `LD_VALID`  in  1  divisor load request.
- `LD_READY`  out  1  load accept; transfer occurs on an edge with `LD_VALID`&`LD_READY`.
- `LD_CH`  in  CH_W  target channel of load.
- `LD_DIV`  in  WIDTH  new terminal value (period = `LD_DIV`+1 `CE` cycles).
- `Q`  out  CHANNELS*WIDTH  counter values, channel i at bits [i*WIDTH +: WIDTH].
- `TICK`  out  CHANNELS  one-cycle pulse per wrap.
- `TGL`  out  CHANNELS  toggles on every wrap.
- `SYNC`  in  1  present only with `MULTI_DIVIDER_SYNC_EN`.

## Operation
- Per channel: `active` divisor, `shadow` divisor, `pending` flag, counter `Q`, `TICK`, `TGL` registers.
- Reset (`RST_N`=0 at an edge): `Q`=0, `TICK`=0, `TGL`=0, `active`=`RESET_DIV`, `pending`=0. Reset mid-count discards count and any pending load.
- Enabled channel, `CE`=1: if `Q`==`active` then `Q`<=0, `TICK`<=1, `TGL`<=~`TGL`; else `Q`<=`Q`+1, `TICK`<=0. `CE`=0: `Q`, `TGL` hold, `TICK`<=0.
- `active`=0: wraps on every `CE` cycle; `TICK` stays high while `CE`=1.
- Disabled channel (`CH_EN[i]`=0): `Q`<=0, `TICK`<=0, `TGL`<=0; a load accepted to it writes `active` directly next edge, `pending` not set.
- Load to enabled channel: `shadow`<=`LD_DIV`, `pending`<=1. At next wrap `active`<=`shadow`, `pending`<=0; that wrap's compare uses old `active`.
- Load accepted on the same edge as a wrap of that channel: goes to `shadow`, applied at the following wrap.
- `LD_READY` = ~`pending[LD_CH]`, combinational from `LD_CH`; loads to other channels proceed while one is pending.
- `LD_CH` >= `CHANNELS`: `LD_READY`=1, data discarded.
- Priority per edge: reset > `SYNC` > disable > count.

## Timing
- `TICK` is registered: high in the cycle where `Q` has just become 0 after a wrap; width exactly one cycle.
- With `CE` stuck high and `active`=D: `TICK` period D+1 cycles, `TGL` period 2(D+1), 50% duty.
- With `CE` every k cycles: `TICK` period k(D+1) cycles, still one cycle wide.
- Load latency: effective from first wrap after accept; worst case D+1 `CE` cycles.
- No combinational path from `CE` or `CH_EN` to outputs; only `LD_READY` is combinational.

## Configuration
- `MULTI_DIVIDER_SYNC_EN` defined: `SYNC` port exists; `SYNC`=1 at an edge sets every enabled channel to `Q`=0, `TICK`=0, `TGL`=0, applies any `pending` `shadow` to `active` and clears `pending`, regardless of `CE`. Used to phase-align channels.
- Undefined: no `SYNC` port, no sync logic; channels align only via reset or enable.

## Test plan
- `RESET_DIV`=4, `CH_EN`=0001, `CE`=1 after reset -> `Q[0]` 0,1,2,3,4,0...; `TICK[0]` high once per 5 cycles; `TGL[0]` period 10.
- Ch1 counting with D=4, load `LD_CH`=1, `LD_DIV`=2 at `Q`=1 -> `LD_READY` low for ch1 until wrap; current period stays 5, then periods of 3; ch0 load accepted meanwhile.
- `CE` high every other cycle, D=3 -> `TICK` every 8 cycles, one cycle wide, `Q` holds on `CE`=0 cycles.
- D=0 via load to disabled ch2, then enable -> `TICK[2]` constant 1 while `CE`=1, `TGL[2]` toggles every cycle.
- `RST_N` low for one edge at `Q`=3 with load pending -> next cycle all `Q`/`TICK`/`TGL` 0, `LD_READY`=1, period back to `RESET_DIV`+1.
- With `MULTI_DIVIDER_SYNC_EN`, channels at differing phases, pulse `SYNC` -> all `Q`=0 next cycle, subsequent `TICK`s of equal-divisor channels coincide.
